// File: rtl/rect_fill_draw.sv
// Rectangle fill source for the shared frame-buffer write bus.
// Solid, checker or outline fill of a screen-clipped rectangle.
module rect_fill_draw #(
  parameter int DRAW_WIDTH  = 640,
  parameter int DRAW_HEIGHT = 480,
  parameter int COORD_W     = 11,
  parameter int COLOR_DEPTH = 9,
  parameter int SEL_W       = 2,
  parameter int SOURCE_ID   = 0,
  parameter int CHECK_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [SEL_W-1:0]       write_source_sel,
  input  logic                   write_awaited,
  input  logic                   write_ready,
  input  logic [COORD_W-1:0]     rect_x,
  input  logic [COORD_W-1:0]     rect_y,
  input  logic [COORD_W-1:0]     rect_w,
  input  logic [COORD_W-1:0]     rect_h,
  input  logic [COLOR_DEPTH-1:0] fill_color,
  input  logic [COLOR_DEPTH-1:0] alt_color,
  input  logic [1:0]             fill_mode,
  output logic                   write_active,
  output logic [COLOR_DEPTH-1:0] write_color_data,
  output logic [COORD_W-1:0]     write_x_addr,
  output logic [COORD_W-1:0]     write_y_addr,
  output logic                   draw_busy,
  output logic                   draw_done
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [SEL_W-1:0] SRC = SEL_W'(SOURCE_ID);
  localparam logic [CW1-1:0] SCR_W = CW1'(DRAW_WIDTH);
  localparam logic [CW1-1:0] SCR_H = CW1'(DRAW_HEIGHT);
  localparam logic [1:0] M_CHECK = 2'd1;
  localparam logic [1:0] M_OUTLINE = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    WRITE,
    DONE
  } state_e;

  state_e                 state_q;
  logic [COORD_W-1:0]     x0_q, x1_q, y0_q, y1_q;
  logic [COORD_W-1:0]     col_q, row_q;
  logic [COORD_W-1:0]     col_d, row_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
  logic [COLOR_DEPTH-1:0] fill_q, alt_q;
  logic [1:0]             mode_q;
  logic                   busy_q, done_q;

  logic                   sel;
  logic                   accept;
  logic                   last;
  logic [CW1-1:0]         x_end, y_end;
  logic [CW1-1:0]         x_lim, y_lim;
  logic [COORD_W-1:0]     lat_x1, lat_y1;
  logic                   lat_empty;
  logic [COORD_W-1:0]     dx, dy;

  assign sel = (write_source_sel == SRC);
  assign accept = sel && write_ready && (state_q == WRITE);
  assign last = (col_q == x1_q) && (row_q == y1_q);

  // Clip against the screen at one extra bit so x+w cannot wrap.
  always_comb begin
    x_end = {1'b0, rect_x} + {1'b0, rect_w};
    y_end = {1'b0, rect_y} + {1'b0, rect_h};
    x_lim = (x_end > SCR_W) ? SCR_W : x_end;
    y_lim = (y_end > SCR_H) ? SCR_H : y_end;
    lat_x1 = COORD_W'(x_lim - CW1'(1));
    lat_y1 = COORD_W'(y_lim - CW1'(1));
    lat_empty = (rect_w == '0) || (rect_h == '0) ||
                ({1'b0, rect_x} >= SCR_W) ||
                ({1'b0, rect_y} >= SCR_H);
  end

  always_comb begin
    col_d = col_q + COORD_W'(1);
    row_d = row_q;
    if (col_q == x1_q) begin
      col_d = x0_q;
      row_d = row_q + COORD_W'(1);
    end else if (mode_q == M_OUTLINE && row_q > y0_q &&
                 row_q < y1_q && col_q == x0_q &&
                 x1_q > x0_q) begin
      col_d = x1_q;
    end
    dx = col_d - x0_q;
    dy = row_d - y0_q;
    color_d = fill_q;
    if (mode_q == M_CHECK && (dx[CHECK_LOG2] ^ dy[CHECK_LOG2]))
      color_d = alt_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      fill_q  <= '0;
      alt_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (write_awaited && sel) begin
            state_q <= LATCH;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          x0_q    <= rect_x;
          x1_q    <= lat_x1;
          y0_q    <= rect_y;
          y1_q    <= lat_y1;
          col_q   <= rect_x;
          row_q   <= rect_y;
          color_q <= fill_color;
          fill_q  <= fill_color;
          alt_q   <= alt_color;
          mode_q  <= fill_mode;
          if (lat_empty) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            col_q   <= col_d;
            row_q   <= row_d;
            color_q <= color_d;
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Release the shared bus whenever another source owns it.
  assign write_active     = sel ? (state_q == WRITE) : 1'bz;
  assign write_color_data = sel ? color_q : 'z;
  assign write_x_addr     = sel ? col_q : 'z;
  assign write_y_addr     = sel ? row_q : 'z;

  assign draw_busy = busy_q;
  assign draw_done = done_q;

endmodule

// File: doc/rect_fill_draw.md
# rect_fill_draw

Parametrised rectangle fill source for the shared frame-buffer write bus. It succeeds the full-screen background painter. It fills a programmable, screen-clipped rectangle in one of three modes: solid, checkerboard or outline. It honours per-pixel back-pressure from the frame-buffer writer. Its bus outputs go high-impedance whenever another source is selected, so several instances share one write port.

## Interface
- `DRAW_WIDTH`, 640: screen width in pixels; columns wrap at this value.
- `DRAW_HEIGHT`, 480: screen height in pixels.
- `COORD_W`, 11: width of coordinate and size fields.
- `COLOR_DEPTH`, 9: bits per pixel colour.
- `SEL_W`, 2: width of `write_source_sel`.
- `SOURCE_ID`, 0: bus-select value owned by this instance.
- `CHECK_LOG2`, 3: checker tile edge is 2^CHECK_LOG2 pixels.
- `clk`, in, 1: single clock, rising edge.
- `resetN`, in, 1: asynchronous, active-low reset.
- `write_source_sel`, in, SEL_W: which source currently owns the bus.
- `write_awaited`, in, 1: arbiter requests a draw from the selected source.
- `write_ready`, in, 1: frame-buffer writer accepts the presented pixel this cycle.
- `rect_x`, `rect_y`, in, COORD_W: top-left corner.
- `rect_w`, `rect_h`, in, COORD_W: size in pixels.
- `fill_color`, `alt_color`, in, COLOR_DEPTH: primary and secondary colour.
- `fill_mode`, in, 2: 0 = solid, 1 = checker, 2 = outline, 3 = reserved (treated as solid).
- `write_active`, out (tri-state), 1: pixel valid on the bus.
- `write_color_data`, out (tri-state), COLOR_DEPTH: pixel colour.
- `write_x_addr`, `write_y_addr`, out (tri-state), COORD_W: pixel coordinate.
- `draw_busy`, out, 1: high in states LATCH and WRITE. Never tri-stated.
- `draw_done`, out, 1: one-cycle pulse in state DONE. Never tri-stated.

## Operation
- States are IDLE, LATCH, WRITE and DONE. Reset forces IDLE.
- IDLE → LATCH when `write_awaited` is high and `write_source_sel == SOURCE_ID`.
- LATCH registers all `rect_*`, colour and mode inputs. Later input changes are ignored until the next LATCH.
- LATCH computes the clipped bounds:
  - x0 = rect_x.
  - x1 = min(rect_x + rect_w, DRAW_WIDTH) − 1, computed at COORD_W+1 bits with no overflow.
  - y0 and y1 are computed the same way.
  - column ← x0, row ← y0.
- LATCH → DONE directly if any of: rect_w == 0, rect_h == 0, rect_x ≥ DRAW_WIDTH, rect_y ≥ DRAW_HEIGHT. Otherwise LATCH → WRITE.
- WRITE presents (column, row, colour) with `write_active` = 1.
- A pixel is accepted on a cycle where `write_active` and `write_ready` are both high and the source is selected. Column and row advance only on acceptance.
- Advance rule:
  - If column == x1: column ← x0 and row ← row + 1.
  - Otherwise: column ← column + 1.
  - Outline mode, interior rows (y0 < row < y1), column == x0 and x1 > x0: column jumps straight to x1.
- Colour per mode:
  - Solid: fill_color.
  - Checker: fill_color if bit CHECK_LOG2 of (column − x0) XOR bit CHECK_LOG2 of (row − y0) is 0, else alt_color.
  - Outline: fill_color.
- WRITE → DONE when the pixel at (x1, y1) is accepted. DONE → IDLE unconditionally after one cycle.
- Bus outputs are driven only while `write_source_sel == SOURCE_ID`; otherwise all four are 'z.
- When selected but not in WRITE: `write_active` = 0 and colour/x/y show the last registered values.
- Deselection during WRITE freezes progress; drawing resumes at the same pixel on reselection.

## Timing
- Reset values: state IDLE; column, row and colour registers 0; `draw_busy` = 0; `draw_done` = 0. Bus outputs are 0 when selected, 'z when not.
- Request sampled in cycle N. LATCH in N+1. First pixel valid in N+2.
- With `write_ready` held high and the source selected, one pixel is accepted per cycle.
- Solid and checker fills take w'·h' WRITE cycles, where w' and h' are the clipped sizes.
- Outline takes 2w' + 2(h'−2) cycles for w', h' ≥ 2. A single-column or single-row outline writes every pixel once.
- `draw_done` is high in the cycle after the last acceptance. IDLE follows one cycle later, and a new request can be sampled in that IDLE cycle.
- `write_awaited` is ignored outside IDLE.
- Asynchronous reset during any state returns to IDLE immediately with the reset values above. No `draw_done` pulse is produced.

## Test plan
- Solid fill: x = 10, y = 20, w = 4, h = 3, `write_ready` = 1 → exactly 12 accepted pixels at x 10..13, y 20..22 in raster order. `draw_done` pulses at N+14.
- Clip: x = 638, y = 478, w = 5, h = 5 → 4 pixels, at (638,478), (639,478), (638,479), (639,479). `draw_done` pulses afterwards.
- Back-pressure: a 2×2 fill with `write_ready` toggling 1,0,0,1,… → each pixel is held stable while ready is 0. Still exactly 4 accepts, with no skipped or duplicated coordinate.
- Modes:
  - Outline 5×4 at (0,0) → 14 pixels; interior (1..3, 1..2) is never written.
  - Checker 16×1 with CHECK_LOG2 = 3 → columns 0..7 are fill_color, columns 8..15 are alt_color.
- Degenerate and shared-bus cases:
  - w = 0 → no `write_active`, and `draw_done` at N+2.
  - Deselect mid-fill → all bus outputs 'z and the pixel index is frozen. Reselect → drawing resumes at the frozen pixel.
- Reset: assert `resetN` low mid-WRITE → state returns to IDLE and outputs go to their reset values asynchronously. A following request restarts from the top-left pixel.
